// File: rtl/ppr_final_adder_if.sv
// Handshake bundle between the reduction tree, the slice-serial final adder and its consumer.
// The slave side is the adder; the master side drives operands and accepts results.
interface ppr_final_adder_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_s;
   logic [WIDTH-1:0] in_c;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_p;
   logic             out_cout;

   modport slave (
      input  in_valid, in_s, in_c, out_ready,
      output in_ready, out_valid, out_p, out_cout
   );

   modport master (
      output in_valid, in_s, in_c, out_ready,
      input  in_ready, out_valid, out_p, out_cout
   );
endinterface

// File: rtl/ppr_final_adder.sv
// Slice-serial final adder for a carry-save pair: adds SLICE bits per cycle with a rippled
// carry, then presents the WIDTH-bit sum and carry-out under a valid/ready handshake.
module ppr_final_adder #(
   parameter int WIDTH = 16,
   parameter int SLICE = 4
) (
   input logic              clk,
   input logic              resetb,
   ppr_final_adder_if.slave bus
);
   localparam int NSLICE = WIDTH / SLICE;
   localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

   state_t           state_reg;
   logic [WIDTH-1:0] s_reg;
   logic [WIDTH-1:0] c_reg;
   logic [WIDTH-1:0] part_reg;
   logic [WIDTH-1:0] out_p_reg;
   logic [IW-1:0]    idx_reg;
   logic             carry_reg;
   logic             out_cout_reg;

   logic [SLICE-1:0] s_slice [NSLICE];
   logic [SLICE-1:0] c_slice [NSLICE];
   logic [SLICE:0]   slice_sum;
   logic [WIDTH-1:0] part_next;
   logic             last_slice;

   genvar gi;
   generate
      for (gi = 0; gi < NSLICE; gi++) begin : g_slice
         assign s_slice[gi] = s_reg[gi*SLICE +: SLICE];
         assign c_slice[gi] = c_reg[gi*SLICE +: SLICE];
         // Only the slice being processed this cycle takes the fresh sum.
         assign part_next[gi*SLICE +: SLICE] = (idx_reg == IW'(gi)) ? slice_sum[SLICE-1:0]
                                                                    : part_reg[gi*SLICE +: SLICE];
      end
   endgenerate

   always_comb begin
      slice_sum = {1'b0, s_slice[idx_reg]} + {1'b0, c_slice[idx_reg]} + {{SLICE{1'b0}}, carry_reg};
   end

   assign last_slice = (idx_reg == IW'(NSLICE - 1));

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         state_reg    <= IDLE;
         s_reg        <= '0;
         c_reg        <= '0;
         part_reg     <= '0;
         out_p_reg    <= '0;
         idx_reg      <= '0;
         carry_reg    <= 1'b0;
         out_cout_reg <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (bus.in_valid) begin
                  s_reg     <= bus.in_s;
                  c_reg     <= bus.in_c;
                  part_reg  <= '0;
                  idx_reg   <= '0;
                  carry_reg <= 1'b0;
                  state_reg <= ADD;
               end
            end
            ADD: begin
               part_reg  <= part_next;
               carry_reg <= slice_sum[SLICE];
               idx_reg   <= idx_reg + 1'b1;
               if (last_slice) begin
                  // Result registers move only here, so they hold between operations.
                  out_p_reg    <= part_next;
                  out_cout_reg <= slice_sum[SLICE];
                  idx_reg      <= '0;
                  state_reg    <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  state_reg <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = (state_reg == IDLE);
   assign bus.out_valid = (state_reg == DONE);
   assign bus.out_p     = out_p_reg;
   assign bus.out_cout  = out_cout_reg;
endmodule

// File: tb/tb_ppr_final_adder.sv
// Scoreboard bench for ppr_final_adder: expected sums are queued on accept and
// popped when the adder presents a result.
module tb_ppr_final_adder;
   localparam int WIDTH = 16;
   localparam int SLICE = 4;
   localparam int NSLICE = WIDTH / SLICE;

   logic clk;
   logic resetb;
   int   n_cmp;
   int   n_err;
   logic [WIDTH:0] exp_q [$];

   ppr_final_adder_if #(.WIDTH(WIDTH)) bus ();

   ppr_final_adder #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
      .clk    (clk),
      .resetb (resetb),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] c);
      return {1'b0, s} + {1'b0, c};
   endfunction

   // Steps until out_valid is seen or the budget runs out; cycles = -1 on timeout.
   task automatic wait_valid(output int cycles);
      cycles = -1;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (bus.out_valid === 1'b1) begin
            cycles = i;
            break;
         end
      end
   endtask

   task automatic test_reset();
      logic [WIDTH:0] exp_v;
      resetb       = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_s     = 16'hBEEF;
      bus.in_c     = 16'h1357;
      bus.out_ready = 1'b0;
      repeat (3) tick();
      exp_v = '0;
      n_cmp++;
      if (bus.out_valid !== 1'b0) begin
         n_err++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid);
      end
      n_cmp++;
      if ({bus.out_cout, bus.out_p} !== exp_v) begin
         n_err++; $display("FAIL reset_out got %h want %h", {bus.out_cout, bus.out_p}, exp_v);
      end
      n_cmp++;
      if (bus.in_ready !== 1'b1) begin
         n_err++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready);
      end
      $display("test_reset: out_valid=%b out_p=%h out_cout=%b in_ready=%b",
               bus.out_valid, bus.out_p, bus.out_cout, bus.in_ready);
   endtask

   // Accept on the first edge after reset release, then check latency and result.
   task automatic run_single(input string name, input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] c);
      int cyc;
      logic [WIDTH:0] exp_v;
      bus.in_valid  = 1'b1;
      bus.in_s      = s;
      bus.in_c      = c;
      bus.out_ready = 1'b0;
      exp_q.push_back(model(s, c));
      tick();
      bus.in_valid = 1'b0;
      bus.in_s     = ~s;
      bus.in_c     = ~c;
      n_cmp++;
      if (bus.in_ready !== 1'b0) begin
         n_err++; $display("FAIL %s_in_ready_busy got %b want 0", name, bus.in_ready);
      end
      wait_valid(cyc);
      n_cmp++;
      if (cyc != NSLICE) begin
         n_err++; $display("FAIL %s_latency got %0d want %0d", name, cyc, NSLICE);
      end
      if (cyc > 0) begin
         exp_v = exp_q.pop_front();
         n_cmp++;
         if ({bus.out_cout, bus.out_p} !== exp_v) begin
            n_err++; $display("FAIL %s_result got %h want %h", name, {bus.out_cout, bus.out_p}, exp_v);
         end
         $display("%s: s=%h c=%h -> cout=%b p=%h after %0d cycles", name, s, c, bus.out_cout, bus.out_p, cyc);
         bus.out_ready = 1'b1;
         tick();
         bus.out_ready = 1'b0;
         n_cmp++;
         if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_err++; $display("FAIL %s_return_idle got valid=%b ready=%b want 0/1", name, bus.out_valid, bus.in_ready);
         end
         n_cmp++;
         if ({bus.out_cout, bus.out_p} !== exp_v) begin
            n_err++; $display("FAIL %s_hold_idle got %h want %h", name, {bus.out_cout, bus.out_p}, exp_v);
         end
      end else begin
         exp_q.delete();
      end
   endtask

   task automatic test_basic();
      bus.in_valid = 1'b1;
      bus.in_s     = 16'h1234;
      bus.in_c     = 16'h4321;
      resetb       = 1'b1;
      run_single("basic", 16'h1234, 16'h4321);
   endtask

   task automatic test_ripple();
      run_single("ripple", 16'hFFFF, 16'h0001);
   endtask

   task automatic test_backpressure();
      int cyc;
      logic [WIDTH:0] exp_v;
      bus.in_valid  = 1'b1;
      bus.in_s      = 16'h00FF;
      bus.in_c      = 16'h0001;
      bus.out_ready = 1'b0;
      exp_q.push_back(model(16'h00FF, 16'h0001));
      tick();
      bus.in_s = 16'hAAAA;
      bus.in_c = 16'h0001;
      wait_valid(cyc);
      n_cmp++;
      if (cyc != NSLICE) begin
         n_err++; $display("FAIL bp_latency got %0d want %0d", cyc, NSLICE);
      end
      exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      for (int i = 0; i < 10; i++) begin
         n_cmp++;
         if (bus.out_valid !== 1'b1 || {bus.out_cout, bus.out_p} !== exp_v || bus.in_ready !== 1'b0) begin
            n_err++; $display("FAIL bp_hold[%0d] got valid=%b out=%h ready=%b want 1/%h/0",
                              i, bus.out_valid, {bus.out_cout, bus.out_p}, bus.in_ready, exp_v);
         end
         $display("bp hold %0d: valid=%b cout=%b p=%h in_ready=%b", i, bus.out_valid, bus.out_cout, bus.out_p, bus.in_ready);
         tick();
      end
      bus.out_ready = 1'b1;
      tick();
      n_cmp++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         n_err++; $display("FAIL bp_release got ready=%b valid=%b want 1/0", bus.in_ready, bus.out_valid);
      end
      exp_q.push_back(model(16'hAAAA, 16'h0001));
      tick();
      bus.in_valid = 1'b0;
      n_cmp++;
      if (bus.in_ready !== 1'b0) begin
         n_err++; $display("FAIL bp_late_accept got ready=%b want 0", bus.in_ready);
      end
      wait_valid(cyc);
      n_cmp++;
      if (cyc != NSLICE) begin
         n_err++; $display("FAIL bp_second_latency got %0d want %0d", cyc, NSLICE);
      end
      exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      n_cmp++;
      if ({bus.out_cout, bus.out_p} !== exp_v) begin
         n_err++; $display("FAIL bp_second_result got %h want %h", {bus.out_cout, bus.out_p}, exp_v);
      end
      $display("bp second: cout=%b p=%h", bus.out_cout, bus.out_p);
      tick();
      bus.out_ready = 1'b0;
      exp_q.delete();
   endtask

   task automatic test_reset_midop();
      int seen;
      bus.in_valid  = 1'b1;
      bus.in_s      = 16'h1111;
      bus.in_c      = 16'h2222;
      bus.out_ready = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      tick();
      #2;
      resetb = 1'b0;
      #1;
      n_cmp++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_p !== 16'h0000) begin
         n_err++; $display("FAIL midop_async_reset got ready=%b valid=%b p=%h want 1/0/0000",
                           bus.in_ready, bus.out_valid, bus.out_p);
      end
      tick();
      resetb = 1'b1;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (bus.out_valid === 1'b1) seen++;
      end
      n_cmp++;
      if (seen != 0) begin
         n_err++; $display("FAIL midop_no_valid got %0d pulses want 0", seen);
      end
      $display("midop: abandoned op produced %0d valid cycles", seen);
      run_single("after_reset", 16'h0F0F, 16'h00F1);
   endtask

   task automatic test_back_to_back();
      logic [WIDTH-1:0] s_tab [2];
      logic [WIDTH-1:0] c_tab [2];
      logic [WIDTH:0] exp_v;
      int nxt;
      int got;
      int t_first;
      int t_second;
      s_tab[0] = 16'h8000; c_tab[0] = 16'h8000;
      s_tab[1] = 16'h0001; c_tab[1] = 16'h0002;
      nxt = 0; got = 0; t_first = -1; t_second = -1;
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_s      = s_tab[0];
      bus.in_c      = c_tab[0];
      for (int cyc = 0; cyc < 40 && got < 2; cyc++) begin
         if (bus.in_valid && bus.in_ready && nxt < 2) begin
            exp_q.push_back(model(s_tab[nxt], c_tab[nxt]));
            nxt++;
         end
         tick();
         if (nxt < 2) begin
            bus.in_s = s_tab[nxt];
            bus.in_c = c_tab[nxt];
         end else begin
            bus.in_valid = 1'b0;
         end
         if (bus.out_valid === 1'b1) begin
            exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            n_cmp++;
            if ({bus.out_cout, bus.out_p} !== exp_v) begin
               n_err++; $display("FAIL b2b_result[%0d] got %h want %h", got, {bus.out_cout, bus.out_p}, exp_v);
            end
            $display("b2b result %0d at cycle %0d: cout=%b p=%h", got, cyc, bus.out_cout, bus.out_p);
            if (got == 0) t_first = cyc; else t_second = cyc;
            got++;
         end
      end
      n_cmp++;
      if (got != 2 || (t_second - t_first) != NSLICE + 2) begin
         n_err++; $display("FAIL b2b_spacing got %0d results %0d apart want 2 results %0d apart",
                           got, t_second - t_first, NSLICE + 2);
      end
      bus.in_valid = 1'b0;
      exp_q.delete();
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      test_reset();
      test_basic();
      test_ripple();
      test_backpressure();
      test_reset_midop();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
